// File: rtl/reuleaux_triangle.sv
// -----------------------------------------------------------------------------
// reuleaux_triangle
// Traces a Reuleaux triangle outline as three midpoint-circle arcs. Each arc
// has radius = diameter and is centred on one vertex of the equilateral
// triangle around (centre_x, centre_y). One candidate pixel is emitted per
// cycle, and vga_plot marks the candidates that lie on the wanted arc segment.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   colour             outline colour, latched on start
//   centre_x/centre_y  triangle centre, latched on start
//   diameter           Reuleaux diameter (= arc radius), latched on start
//   start              level request, held until done is seen
//   done               drawing complete (held while start stays high)
//   vga_x/vga_y        candidate pixel (low bits of the signed coordinate)
//   vga_colour         latched colour
//   vga_plot           write strobe for the candidate pixel
// -----------------------------------------------------------------------------
module reuleaux_triangle #(
   parameter int unsigned SCREEN_W = 160,
   parameter int unsigned SCREEN_H = 120
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] colour,
   input  logic [7:0] centre_x,
   input  logic [6:0] centre_y,
   input  logic [7:0] diameter,
   input  logic       start,
   output logic       done,
   output logic [7:0] vga_x,
   output logic [6:0] vga_y,
   output logic [2:0] vga_colour,
   output logic       vga_plot
);

   // Signed working width for coordinates, offsets and the decision variable
   localparam int unsigned CW = 12;
   // Width of the d*k products used for the rounded sqrt3 heights
   localparam int unsigned MW = 18;

   localparam logic signed [CW-1:0] ONE  = CW'(1);
   localparam logic signed [CW-1:0] ZERO = CW'(0);
   localparam logic signed [CW-1:0] SW_S = CW'(SCREEN_W);
   localparam logic signed [CW-1:0] SH_S = CW'(SCREEN_H);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_INIT  = 3'd1,
      S_ARC_C = 3'd2,
      S_ARC_A = 3'd3,
      S_ARC_B = 3'd4,
      S_DONE  = 3'd5
   } state_e;

   state_e state_q, state_d;

   logic [2:0]           colour_q, colour_d;
   logic signed [CW-1:0] cx_q, cx_d;
   logic signed [CW-1:0] cy_q, cy_d;
   logic [7:0]           d_q, d_d;
   logic signed [CW-1:0] ax_q, ax_d;     // vertex A x
   logic signed [CW-1:0] bx_q, bx_d;     // vertex B x
   logic signed [CW-1:0] ay_q, ay_d;     // shared y of vertices A and B
   logic signed [CW-1:0] top_q, top_d;   // vertex C y (C.x = centre x)
   logic signed [CW-1:0] ox_q, ox_d;
   logic signed [CW-1:0] oy_q, oy_d;
   logic signed [CW-1:0] crit_q, crit_d;
   logic [2:0]           oct_q, oct_d;   // which of the 8 symmetric points
   logic [7:0]           vga_x_q, vga_x_d;
   logic [6:0]           vga_y_q, vga_y_d;
   logic                 plot_q, plot_d;
   logic                 done_q, done_d;

   // Datapath helpers
   logic [MW-1:0]        hs_prod, ht_prod;
   logic signed [CW-1:0] hs, ht, half, r_init;
   logic signed [CW-1:0] vx, vy;
   logic signed [CW-1:0] cand_x, cand_y;
   logic signed [CW-1:0] ox_n, oy_n, crit_n;
   logic                 on_screen, seg_ok;
   state_e               next_arc;

   // Rounded triangle heights and half-width from the latched diameter
   always_comb begin
      hs_prod = MW'(d_q) * MW'(296) + MW'(512);
      ht_prod = MW'(d_q) * MW'(591) + MW'(512);
      hs      = CW'(hs_prod >> 10);
      ht      = CW'(ht_prod >> 10);
      half    = CW'(d_q >> 1);
      r_init  = CW'(d_q);
   end

   // Vertex of the arc being traced and the arc that follows it
   always_comb begin
      vx       = cx_q;
      vy       = top_q;
      next_arc = S_DONE;
      case (state_q)
         S_ARC_C: begin vx = cx_q; vy = top_q; next_arc = S_ARC_A; end
         S_ARC_A: begin vx = ax_q; vy = ay_q;  next_arc = S_ARC_B; end
         S_ARC_B: begin vx = bx_q; vy = ay_q;  next_arc = S_DONE;  end
         default: begin vx = cx_q; vy = top_q; next_arc = S_DONE;  end
      endcase
   end

   // Candidate pixel for the current octant point
   always_comb begin
      cand_x = vx;
      cand_y = vy;
      case (oct_q)
         3'd0:    begin cand_x = vx + ox_q; cand_y = vy + oy_q; end
         3'd1:    begin cand_x = vx + oy_q; cand_y = vy + ox_q; end
         3'd2:    begin cand_x = vx - oy_q; cand_y = vy + ox_q; end
         3'd3:    begin cand_x = vx - ox_q; cand_y = vy + oy_q; end
         3'd4:    begin cand_x = vx - ox_q; cand_y = vy - oy_q; end
         3'd5:    begin cand_x = vx - oy_q; cand_y = vy - ox_q; end
         3'd6:    begin cand_x = vx + oy_q; cand_y = vy - ox_q; end
         default: begin cand_x = vx + ox_q; cand_y = vy - oy_q; end
      endcase
   end

   // Keep only on-screen pixels that belong to this arc's segment
   always_comb begin
      on_screen = (cand_x >= ZERO) && (cand_x < SW_S) &&
                  (cand_y >= ZERO) && (cand_y < SH_S);
      seg_ok    = 1'b0;
      case (state_q)
         S_ARC_C: seg_ok = (cand_y >= ay_q);
         S_ARC_A: seg_ok = (cand_x <= cx_q) && (cand_y <= ay_q);
         S_ARC_B: seg_ok = (cand_x >= cx_q) && (cand_y <= ay_q);
         default: seg_ok = 1'b0;
      endcase
   end

   // Midpoint-circle step applied after the 8th point of an iteration
   always_comb begin
      oy_n = oy_q + ONE;
      if (crit_q <= ZERO) begin
         ox_n   = ox_q;
         crit_n = crit_q + (oy_n <<< 1) + ONE;
      end else begin
         ox_n   = ox_q - ONE;
         crit_n = crit_q + ((oy_n - ox_n) <<< 1) + ONE;
      end
   end

   // Next-state and register-input logic
   always_comb begin
      state_d  = state_q;
      colour_d = colour_q;
      cx_d     = cx_q;
      cy_d     = cy_q;
      d_d      = d_q;
      ax_d     = ax_q;
      bx_d     = bx_q;
      ay_d     = ay_q;
      top_d    = top_q;
      ox_d     = ox_q;
      oy_d     = oy_q;
      crit_d   = crit_q;
      oct_d    = oct_q;
      vga_x_d  = vga_x_q;
      vga_y_d  = vga_y_q;
      plot_d   = 1'b0;
      done_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               colour_d = colour;
               cx_d     = CW'(centre_x);
               cy_d     = CW'(centre_y);
               d_d      = diameter;
               state_d  = S_INIT;
            end
         end

         S_INIT: begin
            ax_d    = cx_q + half;
            bx_d    = cx_q - half;
            ay_d    = cy_q + hs;
            top_d   = cy_q - ht;
            ox_d    = r_init;
            oy_d    = ZERO;
            crit_d  = ONE - r_init;
            oct_d   = 3'd0;
            state_d = S_ARC_C;
         end

         S_ARC_C, S_ARC_A, S_ARC_B: begin
            vga_x_d = cand_x[7:0];
            vga_y_d = cand_y[6:0];
            plot_d  = on_screen && seg_ok;
            if (oct_q == 3'd7) begin
               oct_d = 3'd0;
               if (oy_n <= ox_n) begin
                  ox_d   = ox_n;
                  oy_d   = oy_n;
                  crit_d = crit_n;
               end else begin
                  // Arc finished: restart the circle for the next vertex
                  ox_d    = r_init;
                  oy_d    = ZERO;
                  crit_d  = ONE - r_init;
                  state_d = next_arc;
               end
            end else begin
               oct_d = oct_q + 3'd1;
            end
         end

         S_DONE: begin
            done_d = start;
            if (!start) begin
               state_d = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         colour_q <= '0;
         cx_q     <= '0;
         cy_q     <= '0;
         d_q      <= '0;
         ax_q     <= '0;
         bx_q     <= '0;
         ay_q     <= '0;
         top_q    <= '0;
         ox_q     <= '0;
         oy_q     <= '0;
         crit_q   <= '0;
         oct_q    <= '0;
         vga_x_q  <= '0;
         vga_y_q  <= '0;
         plot_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         colour_q <= colour_d;
         cx_q     <= cx_d;
         cy_q     <= cy_d;
         d_q      <= d_d;
         ax_q     <= ax_d;
         bx_q     <= bx_d;
         ay_q     <= ay_d;
         top_q    <= top_d;
         ox_q     <= ox_d;
         oy_q     <= oy_d;
         crit_q   <= crit_d;
         oct_q    <= oct_d;
         vga_x_q  <= vga_x_d;
         vga_y_q  <= vga_y_d;
         plot_q   <= plot_d;
         done_q   <= done_d;
      end
   end

   assign done       = done_q;
   assign vga_x      = vga_x_q;
   assign vga_y      = vga_y_q;
   assign vga_colour = colour_q;
   assign vga_plot   = plot_q;

endmodule

// File: tb/tb_reuleaux_triangle.sv
// -----------------------------------------------------------------------------
// tb_reuleaux_triangle
// Drives directed and random draws and compares every candidate pixel, the
// plot strobe and the done handshake with a behavioural model of the outline.
// -----------------------------------------------------------------------------
module tb_reuleaux_triangle;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] colour;
   logic [7:0] centre_x;
   logic [6:0] centre_y;
   logic [7:0] diameter;
   logic       start;
   logic       done;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_colour;
   logic       vga_plot;

   int n_checks = 0;
   int n_errors = 0;

   reuleaux_triangle dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .colour     (colour),
      .centre_x   (centre_x),
      .centre_y   (centre_y),
      .diameter   (diameter),
      .start      (start),
      .done       (done),
      .vga_x      (vga_x),
      .vga_y      (vga_y),
      .vga_colour (vga_colour),
      .vga_plot   (vga_plot)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full draw. drop_at: candidate index after which start is released
   // (-1 = hold). abort_at: candidate index after which reset is pulsed.
   task automatic run_draw(input int col, input int cx, input int cy, input int d,
                           input int drop_at, input int abort_at);
      int ex[$];
      int ey[$];
      int ep[$];
      int vxs[3];
      int vys[3];
      int hs, ht, h, ay;
      int ox, oy, crit, px, py, n;
      bit on, seg, held;

      // Reference outline from the geometric description
      hs = (d * 296 + 512) / 1024;
      ht = (d * 591 + 512) / 1024;
      h  = d / 2;
      ay = cy + hs;
      vxs[0] = cx;     vys[0] = cy - ht;
      vxs[1] = cx + h; vys[1] = ay;
      vxs[2] = cx - h; vys[2] = ay;
      for (int a = 0; a < 3; a++) begin
         ox = d; oy = 0; crit = 1 - d;
         do begin
            for (int j = 0; j < 8; j++) begin
               case (j)
                  0: begin px = vxs[a] + ox; py = vys[a] + oy; end
                  1: begin px = vxs[a] + oy; py = vys[a] + ox; end
                  2: begin px = vxs[a] - oy; py = vys[a] + ox; end
                  3: begin px = vxs[a] - ox; py = vys[a] + oy; end
                  4: begin px = vxs[a] - ox; py = vys[a] - oy; end
                  5: begin px = vxs[a] - oy; py = vys[a] - ox; end
                  6: begin px = vxs[a] + oy; py = vys[a] - ox; end
                  default: begin px = vxs[a] + ox; py = vys[a] - oy; end
               endcase
               on = (px >= 0) && (px < 160) && (py >= 0) && (py < 120);
               if (a == 0)      seg = (py >= ay);
               else if (a == 1) seg = (px <= cx) && (py <= ay);
               else             seg = (px >= cx) && (py <= ay);
               ex.push_back(px & 255);
               ey.push_back(py & 127);
               ep.push_back(int'(on && seg));
            end
            oy++;
            if (crit <= 0) crit += 2 * oy + 1;
            else begin
               ox--;
               crit += 2 * (oy - ox) + 1;
            end
         end while (oy <= ox);
      end
      n = ex.size();

      colour   = 3'(col);
      centre_x = 8'(cx);
      centre_y = 7'(cy);
      diameter = 8'(d);
      start    = 1'b1;
      tick();                         // start accepted here
      colour   = 3'($urandom_range(7));
      centre_x = 8'($urandom_range(255));
      centre_y = 7'($urandom_range(127));
      diameter = 8'($urandom_range(255));
      tick();                         // vertex set-up
      for (int i = 0; i < n; i++) begin
         tick();
         chk("cand_x", int'(vga_x), ex[i]);
         chk("cand_y", int'(vga_y), ey[i]);
         chk("plot", int'(vga_plot), ep[i]);
         chk("busy_done", int'(done), 0);
         if (i == 0) chk("colour", int'(vga_colour), col);
         if (i == drop_at) start = 1'b0;
         if (i == abort_at) begin
            rst_n = 1'b0;
            start = 1'b0;
            #1;
            chk("abort_done", int'(done), 0);
            chk("abort_plot", int'(vga_plot), 0);
            chk("abort_x", int'(vga_x), 0);
            chk("abort_y", int'(vga_y), 0);
            chk("abort_colour", int'(vga_colour), 0);
            tick();
            rst_n = 1'b1;
            return;
         end
      end
      held = start;
      tick();
      chk("done", int'(done), int'(held));
      chk("done_plot", int'(vga_plot), 0);
      if (held) begin
         start = 1'b0;
         tick();
         chk("done_release", int'(done), 0);
         chk("idle_plot", int'(vga_plot), 0);
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      colour   = '0;
      centre_x = '0;
      centre_y = '0;
      diameter = '0;
      repeat (2) tick();
      chk("rst_done", int'(done), 0);
      chk("rst_plot", int'(vga_plot), 0);
      chk("rst_x", int'(vga_x), 0);
      chk("rst_y", int'(vga_y), 0);
      chk("rst_colour", int'(vga_colour), 0);
      rst_n = 1'b1;
      tick();

      run_draw(5, 40, 80, 3, -1, -1);     // worked example
      run_draw(2, 2, 2, 20, -1, -1);      // clipping at left/top
      run_draw(1, 40, 80, 3, -1, 30);     // reset during the second arc
      run_draw(6, 40, 80, 3, -1, -1);     // redraw after abort
      run_draw(7, 100, 60, 0, -1, -1);    // zero diameter
      run_draw(4, 80, 60, 255, -1, -1);   // largest diameter
      run_draw(3, 150, 110, 30, -1, -1);  // clipping at right/bottom
      run_draw(2, 70, 50, 12, 20, -1);    // start released mid-draw

      for (int k = 0; k < 12; k++) begin
         run_draw(int'($urandom_range(7)), int'($urandom_range(255)),
                  int'($urandom_range(127)), int'($urandom_range(60)),
                  ($urandom_range(3) == 0) ? int'($urandom_range(30)) : -1, -1);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
